// File: rtl/layer_mixer_pkg.sv
// Shared layer codes, priority modes and palette-address field layout for the layer mixer.
package layer_mixer_pkg;

  typedef enum logic [1:0] {
    LAYER_FX  = 2'b00,
    LAYER_VA  = 2'b01,
    LAYER_VB  = 2'b10,
    LAYER_OBJ = 2'b11
  } layer_t;

  typedef enum logic [1:0] {
    PRI_MODE_0 = 2'd0,
    PRI_MODE_1 = 2'd1,
    PRI_MODE_2 = 2'd2,
    PRI_MODE_3 = 2'd3
  } pri_mode_t;

  localparam int CD_W          = 11;
  localparam int CD_SHADOW_BIT = 10;
  localparam int CD_LAYER_LSB  = 8;

  function automatic logic [CD_W-1:0] make_cd(input logic shadow, input layer_t layer,
                                              input logic [7:0] colour);
    logic [CD_W-1:0] cd;
    cd                                 = '0;
    cd[CD_SHADOW_BIT]                  = shadow;
    cd[CD_LAYER_LSB+1:CD_LAYER_LSB]    = layer;
    cd[7:0]                            = colour;
    return cd;
  endfunction

endpackage

// File: rtl/layer_mixer_if.sv
// Pixel-stream bundle between the tile/sprite sections and the mixer, plus the palette output.
interface layer_mixer_if;
  import layer_mixer_pkg::*;

  logic [11:0]     VA;
  logic [11:0]     VB;
  logic [7:0]      FX;
  logic            NVA;
  logic            NVB;
  logic            NFX;
  logic [7:0]      OB;
  logic            NOBJ;
  logic            OBJ_PRI;
  logic            SHADOW;
  logic            NCBLK;
  logic [CD_W-1:0] CD;
  logic            BLANK_OUT;

  modport master (
    output VA, VB, FX, NVA, NVB, NFX, OB, NOBJ, OBJ_PRI, SHADOW, NCBLK,
    input  CD, BLANK_OUT
  );

  modport slave (
    input  VA, VB, FX, NVA, NVB, NFX, OB, NOBJ, OBJ_PRI, SHADOW, NCBLK,
    output CD, BLANK_OUT
  );
endinterface

// File: rtl/layer_mixer_prio_sel.sv
// Combinational winner selection: first opaque layer in the order given by the priority mode.
module layer_prio_sel
  import layer_mixer_pkg::*;
(
  input  pri_mode_t mode,
  input  logic      nfx,
  input  logic      nva,
  input  logic      nvb,
  input  logic      nobj,
  input  logic      obj_pri,
  output layer_t    winner,
  output logic      all_transparent
);

  always_comb begin
    winner          = LAYER_VB;
    all_transparent = 1'b0;
    unique case (mode)
      // Modes 0/1: high-priority OBJ sits above the first tile layer, low-priority OBJ below it.
      PRI_MODE_0: begin
        if (!nfx)                 winner = LAYER_FX;
        else if (!nobj && obj_pri) winner = LAYER_OBJ;
        else if (!nva)            winner = LAYER_VA;
        else if (!nobj)           winner = LAYER_OBJ;
        else if (!nvb)            winner = LAYER_VB;
        else                      all_transparent = 1'b1;
      end
      PRI_MODE_1: begin
        if (!nfx)                 winner = LAYER_FX;
        else if (!nobj && obj_pri) winner = LAYER_OBJ;
        else if (!nvb)            winner = LAYER_VB;
        else if (!nobj)           winner = LAYER_OBJ;
        else if (!nva)            winner = LAYER_VA;
        else                      all_transparent = 1'b1;
      end
      PRI_MODE_2: begin
        if (!nobj)                winner = LAYER_OBJ;
        else if (!nfx)            winner = LAYER_FX;
        else if (!nva)            winner = LAYER_VA;
        else if (!nvb)            winner = LAYER_VB;
        else                      all_transparent = 1'b1;
      end
      default: begin
        if (!nfx)                 winner = LAYER_FX;
        else if (!nva)            winner = LAYER_VA;
        else if (!nvb)            winner = LAYER_VB;
        else if (!nobj)           winner = LAYER_OBJ;
        else                      all_transparent = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/layer_mixer.sv
// Pixel-rate priority mixer: input register, winner resolve, optional output delay line.
module layer_mixer
  import layer_mixer_pkg::*;
#(
  parameter logic [7:0] BACKDROP   = 8'h00,
  parameter int         PIPE_EXTRA = 0
) (
  input  logic        clk,
  input  logic        nRES,
  input  logic        ce_pix,
  input  logic        pri_wr,
  input  logic [1:0]  pri_din,
  output logic [1:0]  PRI_MODE,
  layer_mixer_if.slave pix
);

  pri_mode_t pri_mode_reg;

  logic [7:0] va_reg, vb_reg, fx_reg, ob_reg;
  logic       nva_reg, nvb_reg, nfx_reg, nobj_reg, obj_pri_reg, shadow_reg, ncblk_reg;
  pri_mode_t  mode_reg;

  logic [CD_W-1:0] cd_pipe_reg    [0:PIPE_EXTRA];
  logic            blank_pipe_reg [0:PIPE_EXTRA];

  layer_t          winner;
  logic            all_transparent;
  logic [7:0]      colour_next;
  logic [CD_W-1:0] cd_next;
  logic            blank_next;

  // Upper pixel bits carry attribute data the palette address does not use.
  logic unused_hi;
  assign unused_hi = ^{pix.VA[11:8], pix.VB[11:8]};

  always_ff @(posedge clk or negedge nRES) begin
    if (!nRES) pri_mode_reg <= PRI_MODE_0;
    else if (pri_wr) pri_mode_reg <= pri_mode_t'(pri_din);
  end

  assign PRI_MODE = pri_mode_reg;

  always_ff @(posedge clk or negedge nRES) begin
    if (!nRES) begin
      va_reg      <= '0;
      vb_reg      <= '0;
      fx_reg      <= '0;
      ob_reg      <= '0;
      nva_reg     <= 1'b0;
      nvb_reg     <= 1'b0;
      nfx_reg     <= 1'b0;
      nobj_reg    <= 1'b0;
      obj_pri_reg <= 1'b0;
      shadow_reg  <= 1'b0;
      ncblk_reg   <= 1'b0;
      mode_reg    <= PRI_MODE_0;
    end else if (ce_pix) begin
      va_reg      <= pix.VA[7:0];
      vb_reg      <= pix.VB[7:0];
      fx_reg      <= pix.FX;
      ob_reg      <= pix.OB;
      nva_reg     <= pix.NVA;
      nvb_reg     <= pix.NVB;
      nfx_reg     <= pix.NFX;
      nobj_reg    <= pix.NOBJ;
      obj_pri_reg <= pix.OBJ_PRI;
      shadow_reg  <= pix.SHADOW;
      ncblk_reg   <= pix.NCBLK;
      mode_reg    <= pri_mode_reg;
    end
  end

  layer_prio_sel u_prio_sel (
    .mode            (mode_reg),
    .nfx             (nfx_reg),
    .nva             (nva_reg),
    .nvb             (nvb_reg),
    .nobj            (nobj_reg),
    .obj_pri         (obj_pri_reg),
    .winner          (winner),
    .all_transparent (all_transparent)
  );

  always_comb begin
    colour_next = BACKDROP;
    if (!all_transparent) begin
      unique case (winner)
        LAYER_FX:  colour_next = fx_reg;
        LAYER_VA:  colour_next = va_reg;
        LAYER_VB:  colour_next = vb_reg;
        default:   colour_next = ob_reg;
      endcase
    end
    // Backdrop keeps the VB layer code because winner defaults to LAYER_VB.
    cd_next    = make_cd(shadow_reg & ~nobj_reg & (winner != LAYER_OBJ), winner, colour_next);
    blank_next = 1'b0;
    if (!ncblk_reg) begin
      cd_next    = '0;
      blank_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRES) begin
    if (!nRES) begin
      for (int i = 0; i <= PIPE_EXTRA; i++) begin
        cd_pipe_reg[i]    <= '0;
        blank_pipe_reg[i] <= 1'b1;
      end
    end else if (ce_pix) begin
      cd_pipe_reg[0]    <= cd_next;
      blank_pipe_reg[0] <= blank_next;
      for (int i = 1; i <= PIPE_EXTRA; i++) begin
        cd_pipe_reg[i]    <= cd_pipe_reg[i-1];
        blank_pipe_reg[i] <= blank_pipe_reg[i-1];
      end
    end
  end

  assign pix.CD        = cd_pipe_reg[PIPE_EXTRA];
  assign pix.BLANK_OUT = blank_pipe_reg[PIPE_EXTRA];

endmodule

// File: tb/tb_layer_mixer.sv
// Directed self-checking bench for layer_mixer: priority modes, backdrop, shadow, blank, stall, reset.
module tb_layer_mixer;

  logic       clk = 1'b0;
  logic       nRES = 1'b0;
  logic       ce_pix = 1'b0;
  logic       pri_wr = 1'b0;
  logic [1:0] pri_din = 2'b00;
  logic [1:0] PRI_MODE;

  int n_tests = 0;
  int n_fail  = 0;

  logic [10:0] cd_hold;
  logic        blank_hold;

  layer_mixer_if pix ();

  layer_mixer #(.BACKDROP(8'h00), .PIPE_EXTRA(0)) dut (
    .clk      (clk),
    .nRES     (nRES),
    .ce_pix   (ce_pix),
    .pri_wr   (pri_wr),
    .pri_din  (pri_din),
    .PRI_MODE (PRI_MODE),
    .pix      (pix.slave)
  );

  always #5 clk = ~clk;

  task automatic set_pix(input logic [11:0] va, input logic [11:0] vb, input logic [7:0] fx,
                         input logic [7:0] ob, input logic nva, input logic nvb, input logic nfx,
                         input logic nobj, input logic obj_pri, input logic shadow,
                         input logic ncblk);
    pix.VA = va; pix.VB = vb; pix.FX = fx; pix.OB = ob;
    pix.NVA = nva; pix.NVB = nvb; pix.NFX = nfx; pix.NOBJ = nobj;
    pix.OBJ_PRI = obj_pri; pix.SHADOW = shadow; pix.NCBLK = ncblk;
  endtask

  // One ce_pix pulse followed by one idle clock; returns 1 ns after an edge.
  task automatic tick();
    ce_pix = 1'b1;
    @(posedge clk); #1;
    ce_pix = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic write_mode(input logic [1:0] m);
    pri_din = m;
    pri_wr  = 1'b1;
    @(posedge clk); #1;
    pri_wr  = 1'b0;
  endtask

  task automatic test_reset();
    nRES = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_pix(12'($urandom), 12'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    n_tests++;
    if (pix.CD !== 11'h000 || pix.BLANK_OUT !== 1'b1 || PRI_MODE !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_state cd=%h blank=%b mode=%0d required cd=000 blank=1 mode=0",
               pix.CD, pix.BLANK_OUT, PRI_MODE);
    end else $display("[TB] reset_state ok");
    nRES = 1'b1;
    @(posedge clk); #1;
    set_pix(12'h000, 12'h000, 8'h3C, 8'h00, 1, 1, 0, 1, 0, 0, 1);
    tick();
    n_tests++;
    if (pix.CD !== 11'h000) begin
      n_fail++;
      $display("[TB] FAIL reset_latency_1 cd=%h required 000", pix.CD);
    end else $display("[TB] reset_latency_1 ok");
    tick();
    n_tests++;
    if (pix.CD !== 11'h03C || pix.BLANK_OUT !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_latency_2 cd=%h blank=%b required 03c 0", pix.CD, pix.BLANK_OUT);
    end else $display("[TB] reset_latency_2 ok");
  endtask

  task automatic test_mode0_sweep();
    write_mode(2'd0);
    set_pix(12'h0AA, 12'h000, 8'h00, 8'h55, 0, 1, 1, 0, 1, 0, 1);
    tick(); tick();
    n_tests++;
    if (pix.CD !== 11'h355) begin
      n_fail++;
      $display("[TB] FAIL m0_objpri1 cd=%h required 355", pix.CD);
    end else $display("[TB] m0_objpri1 ok");
    set_pix(12'h0AA, 12'h000, 8'h00, 8'h55, 0, 1, 1, 0, 0, 0, 1);
    tick(); tick();
    n_tests++;
    if (pix.CD !== 11'h1AA) begin
      n_fail++;
      $display("[TB] FAIL m0_objpri0 cd=%h required 1aa", pix.CD);
    end else $display("[TB] m0_objpri0 ok");
    set_pix(12'h0AA, 12'h011, 8'h00, 8'h55, 1, 0, 1, 0, 0, 0, 1);
    tick(); tick();
    n_tests++;
    if (pix.CD !== 11'h355) begin
      n_fail++;
      $display("[TB] FAIL m0_obj_over_vb cd=%h required 355", pix.CD);
    end else $display("[TB] m0_obj_over_vb ok");
  endtask

  task automatic test_mode1_swap();
    write_mode(2'd1);
    n_tests++;
    if (PRI_MODE !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL pri_readback mode=%0d required 1", PRI_MODE);
    end else $display("[TB] pri_readback ok");
    set_pix(12'h012, 12'h034, 8'h00, 8'h00, 0, 0, 1, 1, 0, 0, 1);
    tick(); tick();
    n_tests++;
    if (pix.CD !== 11'h234) begin
      n_fail++;
      $display("[TB] FAIL m1_vb_wins cd=%h required 234", pix.CD);
    end else $display("[TB] m1_vb_wins ok");
    write_mode(2'd0);
    tick(); tick();
    n_tests++;
    if (pix.CD !== 11'h112) begin
      n_fail++;
      $display("[TB] FAIL m0_va_wins cd=%h required 112", pix.CD);
    end else $display("[TB] m0_va_wins ok");
  endtask

  task automatic test_backdrop_shadow();
    set_pix(12'h0AA, 12'h0BB, 8'h07, 8'h55, 1, 1, 1, 1, 0, 1, 1);
    tick(); tick();
    n_tests++;
    if (pix.CD !== 11'h200) begin
      n_fail++;
      $display("[TB] FAIL backdrop cd=%h required 200", pix.CD);
    end else $display("[TB] backdrop ok");
    set_pix(12'h0AA, 12'h0BB, 8'h07, 8'h55, 1, 1, 0, 0, 0, 1, 1);
    tick(); tick();
    n_tests++;
    if (pix.CD !== 11'h407) begin
      n_fail++;
      $display("[TB] FAIL shadow_fx cd=%h required 407", pix.CD);
    end else $display("[TB] shadow_fx ok");
    write_mode(2'd2);
    tick(); tick();
    n_tests++;
    if (pix.CD !== 11'h355) begin
      n_fail++;
      $display("[TB] FAIL m2_obj_no_shadow cd=%h required 355", pix.CD);
    end else $display("[TB] m2_obj_no_shadow ok");
    write_mode(2'd3);
    set_pix(12'h0AA, 12'h00F, 8'h07, 8'h77, 1, 0, 1, 0, 1, 1, 1);
    tick(); tick();
    n_tests++;
    if (pix.CD !== 11'h60F) begin
      n_fail++;
      $display("[TB] FAIL m3_vb_shadow cd=%h required 60f", pix.CD);
    end else $display("[TB] m3_vb_shadow ok");
    write_mode(2'd0);
  endtask

  task automatic test_blank_stall();
    set_pix(12'h000, 12'h000, 8'h21, 8'h00, 1, 1, 0, 1, 0, 0, 1);
    tick(); tick();
    set_pix(12'h000, 12'h000, 8'h21, 8'h00, 1, 1, 0, 1, 0, 0, 0);
    tick();
    n_tests++;
    if (pix.CD !== 11'h021 || pix.BLANK_OUT !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL blank_latency_1 cd=%h blank=%b required 021 0", pix.CD, pix.BLANK_OUT);
    end else $display("[TB] blank_latency_1 ok");
    tick();
    n_tests++;
    if (pix.CD !== 11'h000 || pix.BLANK_OUT !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL blank_override cd=%h blank=%b required 000 1", pix.CD, pix.BLANK_OUT);
    end else $display("[TB] blank_override ok");
    set_pix(12'h000, 12'h000, 8'h44, 8'h00, 1, 1, 0, 1, 0, 0, 1);
    tick(); tick();
    cd_hold    = pix.CD;
    blank_hold = pix.BLANK_OUT;
    set_pix(12'h099, 12'h000, 8'h00, 8'h00, 0, 1, 1, 1, 0, 0, 1);
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (pix.CD !== 11'h044 || cd_hold !== 11'h044 || pix.BLANK_OUT !== blank_hold) begin
      n_fail++;
      $display("[TB] FAIL stall_hold cd=%h blank=%b required 044 %b", pix.CD, pix.BLANK_OUT,
               blank_hold);
    end else $display("[TB] stall_hold ok");
  endtask

  task automatic test_mid_pixel_wr();
    write_mode(2'd0);
    set_pix(12'h012, 12'h034, 8'h00, 8'h00, 0, 0, 1, 1, 0, 0, 1);
    tick(); tick();
    pri_din = 2'd1;
    pri_wr  = 1'b1;
    ce_pix  = 1'b1;
    @(posedge clk); #1;
    pri_wr  = 1'b0;
    ce_pix  = 1'b0;
    @(posedge clk); #1;
    tick();
    n_tests++;
    if (pix.CD !== 11'h112) begin
      n_fail++;
      $display("[TB] FAIL midwr_old_mode cd=%h required 112", pix.CD);
    end else $display("[TB] midwr_old_mode ok");
    tick();
    n_tests++;
    if (pix.CD !== 11'h234) begin
      n_fail++;
      $display("[TB] FAIL midwr_new_mode cd=%h required 234", pix.CD);
    end else $display("[TB] midwr_new_mode ok");
  endtask

  task automatic test_async_reset();
    @(posedge clk); #2;
    nRES = 1'b0;
    #1;
    n_tests++;
    if (pix.CD !== 11'h000 || pix.BLANK_OUT !== 1'b1 || PRI_MODE !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL async_reset cd=%h blank=%b mode=%0d required 000 1 0", pix.CD,
               pix.BLANK_OUT, PRI_MODE);
    end else $display("[TB] async_reset ok");
    @(posedge clk); #1;
    nRES = 1'b1;
  endtask

  initial begin
    set_pix(12'h000, 12'h000, 8'h00, 8'h00, 1, 1, 1, 1, 0, 0, 1);
    test_reset();
    test_mode0_sweep();
    test_mode1_swap();
    test_backdrop_shadow();
    test_blank_stall();
    test_mid_pixel_wr();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
